efuse_pgm_verify_ctrl: RTL



---
 rtl/efuse_pgm_verify_ctrl_if.sv | 40 ++++
 rtl/efuse_pgm_verify_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/efuse_pgm_verify_ctrl_if.sv
// efuse_pgm_verify_ctrl_if: request/status and eFuse macro signals of the sequencer.
// master = register block + macro side, slave = sequencer.
interface efuse_pgm_verify_ctrl_if #(
    parameter int NBITS = 256,
    parameter int DW    = 8,
    parameter int NW    = 64
);
    localparam int SELW = (NBITS / NW > 1) ? $clog2(NBITS / NW) : 1;
    localparam int AW   = $clog2(NBITS);

    logic            i_start;
    logic            i_mode;
    logic [SELW-1:0] i_sel;
    logic [NW-1:0]   i_wdata;
    logic [15:0]     i_password;
    logic [5:0]      i_trd;
    logic [9:0]      i_tpgm;
    logic            o_busy;
    logic            o_done;
    logic [1:0]      o_status;
    logic [NW-1:0]   o_rdata;
    logic [2:0]      o_retry_cnt;
    logic            o_efuse_pgmen;
    logic            o_efuse_rden;
    logic            o_efuse_aen;
    logic [AW-1:0]   o_efuse_addr;
    logic [DW-1:0]   i_efuse_rdata;

    modport slave (
        input  i_start, i_mode, i_sel, i_wdata, i_password, i_trd, i_tpgm, i_efuse_rdata,
        output o_busy, o_done, o_status, o_rdata, o_retry_cnt,
               o_efuse_pgmen, o_efuse_rden, o_efuse_aen, o_efuse_addr
    );

    modport master (
        output i_start, i_mode, i_sel, i_wdata, i_password, i_trd, i_tpgm, i_efuse_rdata,
        input  o_busy, o_done, o_status, o_rdata, o_retry_cnt,
               o_efuse_pgmen, o_efuse_rden, o_efuse_aen, o_efuse_addr
    );
endinterface

// File: rtl/efuse_pgm_verify_ctrl.sv
// efuse_pgm_verify_ctrl: eFuse word read, bit-serial program, read-back verify with bounded retry.
// Optional macro EFUSE_BLANK_CHECK_EN: pre-read the target word before programming and
// end with status 3 (no program strobe) if any bit is already blown.
//
// state    | meaning
// IDLE     | waiting for start
// CHK      | password check, choose read or program path
// RD_SU    | read setup, rden high
// RD_STB   | read strobe, aen high for trd cycles, byte captured on last cycle
// RD_HD    | read hold, advance to next byte
// PG_SCAN  | walk pending mask, one cycle per bit
// PG_SU    | program setup, pgmen high
// PG_STB   | program strobe, aen high for tpgm cycles
// PG_HD    | program hold, advance to next bit
// DONE     | done pulse, status/rdata/retry_cnt valid
module efuse_pgm_verify_ctrl #(
    parameter int          NBITS     = 256,
    parameter int          DW        = 8,
    parameter int          NW        = 64,
    parameter int          MAX_RETRY = 3,
    parameter logic [15:0] PASSWORD  = 16'hA5C3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    efuse_pgm_verify_ctrl_if.slave bus
);
    localparam int SELW = (NBITS / NW > 1) ? $clog2(NBITS / NW) : 1;
    localparam int AW   = $clog2(NBITS);
    localparam int NB   = NW / DW;
    localparam int KW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW   = $clog2(NW);

    typedef enum logic [3:0] {
        S_IDLE, S_CHK, S_RD_SU, S_RD_STB, S_RD_HD,
        S_PG_SCAN, S_PG_SU, S_PG_STB, S_PG_HD, S_DONE
    } state_t;

    localparam logic [1:0] PH_READ   = 2'd0;
    localparam logic [1:0] PH_VERIFY = 2'd2;
`ifdef EFUSE_BLANK_CHECK_EN
    localparam logic [1:0] PH_BLANK  = 2'd1;
`endif

    state_t          r_state, w_next;
    logic            r_mode, r_pw_ok;
    logic [SELW-1:0] r_sel;
    logic [NW-1:0]   r_wdata, r_mask, r_word, r_rdata;
    logic [5:0]      r_trd;
    logic [9:0]      r_tpgm, r_tmr;
    logic [KW-1:0]   r_k;
    logic [IW-1:0]   r_i;
    logic [2:0]      r_retry, r_retry_cnt;
    logic [1:0]      r_phase, r_status;

    logic            w_last_k, w_last_i, w_tmr_zero, w_bit;
    logic [NW-1:0]   w_fail, w_mask_nx;
    logic            w_rd_begin, w_pg_begin, w_finish, w_retry;
    logic [1:0]      w_phase_nx, w_status_nx;
    logic            w_rden, w_pgmen, w_aen;
    logic [AW-1:0]   w_base, w_addr;

    assign w_last_k   = (r_k == KW'(NB - 1));
    assign w_last_i   = (r_i == IW'(NW - 1));
    assign w_tmr_zero = (r_tmr == '0);
    assign w_bit      = r_mask[r_i];
    assign w_fail     = r_wdata & ~r_word;
    assign w_base     = AW'(r_sel) << IW;

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state, macro strobes and datapath load requests
    always_comb begin
        w_next      = r_state;
        w_rden      = 1'b0;
        w_pgmen     = 1'b0;
        w_aen       = 1'b0;
        w_rd_begin  = 1'b0;
        w_pg_begin  = 1'b0;
        w_finish    = 1'b0;
        w_retry     = 1'b0;
        w_phase_nx  = PH_READ;
        w_status_nx = 2'd0;
        w_mask_nx   = r_wdata;
        case (r_state)
            S_IDLE: if (bus.i_start) w_next = S_CHK;
            S_CHK: begin
                if (!r_mode) begin
                    w_next = S_RD_SU; w_rd_begin = 1'b1; w_phase_nx = PH_READ;
                end else if (!r_pw_ok) begin
                    w_next = S_DONE; w_finish = 1'b1; w_status_nx = 2'd2;
`ifdef EFUSE_BLANK_CHECK_EN
                end else begin
                    w_next = S_RD_SU; w_rd_begin = 1'b1; w_phase_nx = PH_BLANK;
                end
`else
                end else if (r_wdata == '0) begin
                    w_next = S_RD_SU; w_rd_begin = 1'b1; w_phase_nx = PH_VERIFY;
                end else begin
                    w_next = S_PG_SCAN; w_pg_begin = 1'b1;
                end
`endif
            end
            S_RD_SU: begin
                w_rden = 1'b1;
                w_next = S_RD_STB;
            end
            S_RD_STB: begin
                w_rden = 1'b1;
                w_aen  = 1'b1;
                if (w_tmr_zero) w_next = S_RD_HD;
            end
            S_RD_HD: begin
                w_rden = 1'b1;
                if (!w_last_k) begin
                    w_next = S_RD_SU;
                end else begin
                    case (r_phase)
`ifdef EFUSE_BLANK_CHECK_EN
                        PH_BLANK: begin
                            if (r_word != '0) begin
                                w_next = S_DONE; w_finish = 1'b1; w_status_nx = 2'd3;
                            end else if (r_wdata == '0) begin
                                w_next = S_RD_SU; w_rd_begin = 1'b1; w_phase_nx = PH_VERIFY;
                            end else begin
                                w_next = S_PG_SCAN; w_pg_begin = 1'b1;
                            end
                        end
`endif
                        PH_VERIFY: begin
                            if (w_fail == '0) begin
                                w_next = S_DONE; w_finish = 1'b1; w_status_nx = 2'd0;
                            end else if (r_retry < 3'(MAX_RETRY)) begin
                                w_next = S_PG_SCAN; w_pg_begin = 1'b1;
                                w_mask_nx = w_fail; w_retry = 1'b1;
                            end else begin
                                w_next = S_DONE; w_finish = 1'b1; w_status_nx = 2'd1;
                            end
                        end
                        default: begin
                            w_next = S_DONE; w_finish = 1'b1; w_status_nx = 2'd0;
                        end
                    endcase
                end
            end
            S_PG_SCAN: begin
                if (w_bit) begin
                    w_next = S_PG_SU;
                end else if (w_last_i) begin
                    w_next = S_RD_SU; w_rd_begin = 1'b1; w_phase_nx = PH_VERIFY;
                end
            end
            S_PG_SU: begin
                w_pgmen = 1'b1;
                w_next  = S_PG_STB;
            end
            S_PG_STB: begin
                w_pgmen = 1'b1;
                w_aen   = 1'b1;
                if (w_tmr_zero) w_next = S_PG_HD;
            end
            S_PG_HD: begin
                w_pgmen = 1'b1;
                if (w_last_i) begin
                    w_next = S_RD_SU; w_rd_begin = 1'b1; w_phase_nx = PH_VERIFY;
                end else begin
                    w_next = S_PG_SCAN;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // macro bit address: byte base while reading, bit position while programming
    always_comb begin
        w_addr = '0;
        if (w_rden)       w_addr = w_base + AW'(int'(r_k) * DW);
        else if (w_pgmen) w_addr = w_base + AW'(r_i);
    end

    // request latch, timers, byte/bit counters, word assembly and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode <= 1'b0; r_pw_ok <= 1'b0; r_sel <= '0; r_wdata <= '0;
            r_trd <= 6'd1; r_tpgm <= 10'd1; r_tmr <= '0; r_k <= '0; r_i <= '0;
            r_mask <= '0; r_word <= '0; r_retry <= '0; r_phase <= PH_READ;
            r_status <= 2'd0; r_rdata <= '0; r_retry_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && bus.i_start) begin
                r_mode  <= bus.i_mode;
                r_pw_ok <= (bus.i_password == PASSWORD);
                r_sel   <= bus.i_sel;
                r_wdata <= bus.i_wdata;
                r_trd   <= (bus.i_trd == '0) ? 6'd1 : bus.i_trd;
                r_tpgm  <= (bus.i_tpgm == '0) ? 10'd1 : bus.i_tpgm;
                r_word  <= '0;
                r_retry <= '0;
            end
            if (r_state == S_RD_SU)      r_tmr <= 10'(r_trd) - 10'd1;
            else if (r_state == S_PG_SU) r_tmr <= r_tpgm - 10'd1;
            else if (!w_tmr_zero)        r_tmr <= r_tmr - 10'd1;
            if (w_rd_begin) begin
                r_k     <= '0;
                r_phase <= w_phase_nx;
            end else if (r_state == S_RD_HD && !w_last_k) begin
                r_k <= r_k + KW'(1);
            end
            if (r_state == S_RD_STB && w_tmr_zero) r_word[int'(r_k)*DW +: DW] <= bus.i_efuse_rdata;
            if (w_pg_begin) begin
                r_i    <= '0;
                r_mask <= w_mask_nx;
            end else if ((r_state == S_PG_SCAN && !w_bit) || r_state == S_PG_HD) begin
                r_i <= r_i + IW'(1);
            end
            if (w_retry) r_retry <= r_retry + 3'd1;
            if (w_finish) begin
                r_status    <= w_status_nx;
                r_rdata     <= r_word;
                r_retry_cnt <= r_retry;
            end
        end
    end

    assign bus.o_busy        = (r_state != S_IDLE);
    assign bus.o_done        = (r_state == S_DONE);
    assign bus.o_status      = r_status;
    assign bus.o_rdata       = r_rdata;
    assign bus.o_retry_cnt   = r_retry_cnt;
    assign bus.o_efuse_pgmen = w_pgmen;
    assign bus.o_efuse_rden  = w_rden;
    assign bus.o_efuse_aen   = w_aen;
    assign bus.o_efuse_addr  = w_addr;
endmodule
